hazard_stall_unit: RTL

//  Pipeline control master that drives the NOP-insert select of the control-unit mux, the operand

---
 rtl/hazard_stall_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use bubble, data-memory wait freeze with timeout,
// operand forwarding selects and a saturating stall-cycle counter.
module hazard_stall_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic [3:0]       id_rn_i,
    input  logic [3:0]       id_rm_i,
    input  logic [3:0]       id_rd_i,
    input  logic [2:0]       id_use_i,
    input  logic [3:0]       ex_rd_i,
    input  logic             ex_rf_we_i,
    input  logic             ex_load_i,
    input  logic [3:0]       mem_rd_i,
    input  logic             mem_rf_we_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    input  logic [3:0]       wb_rd_i,
    input  logic             wb_rf_we_i,
    output logic             pc_ld_o,
    output logic             ifid_ld_o,
    output logic             cu_nop_o,
    output logic             pipe_hold_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [1:0]       fwd_c_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_count_o
);

    typedef enum logic {ST_RUN, ST_MEMWAIT} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic freeze;
    logic load_use;

    // r15 is the PC and never forwarded or hazarded; EX loads cannot forward.
    function automatic logic [1:0] fwd_sel(input logic [3:0] src, input logic used,
                                           input logic [3:0] ex_rd, input logic ex_hit_ok,
                                           input logic [3:0] mem_rd, input logic mem_we,
                                           input logic [3:0] wb_rd, input logic wb_we);
        logic [1:0] sel;
        sel = 2'b00;
        if (used && src != 4'd15) begin
            if (ex_hit_ok && ex_rd == src)      sel = 2'b01;
            else if (mem_we && mem_rd == src)   sel = 2'b10;
            else if (wb_we && wb_rd == src)     sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        freeze   = (state_q == ST_MEMWAIT) || (mem_req_i && !mem_ready_i);
        load_use = ex_load_i && ex_rf_we_i && (ex_rd_i != 4'd15) &&
                   ((id_use_i[0] && id_rn_i == ex_rd_i) ||
                    (id_use_i[1] && id_rm_i == ex_rd_i) ||
                    (id_use_i[2] && id_rd_i == ex_rd_i));

        pc_ld_o     = 1'b1;
        ifid_ld_o   = 1'b1;
        cu_nop_o    = 1'b0;
        pipe_hold_o = 1'b0;
        fwd_a_o     = 2'b00;
        fwd_b_o     = 2'b00;
        fwd_c_o     = 2'b00;

        if (!clr_i) begin
            pc_ld_o   = 1'b0;
            ifid_ld_o = 1'b0;
            cu_nop_o  = 1'b1;
        end else begin
            if (freeze) begin
                pc_ld_o     = 1'b0;
                ifid_ld_o   = 1'b0;
                pipe_hold_o = 1'b1;
            end else if (load_use) begin
                pc_ld_o   = 1'b0;
                ifid_ld_o = 1'b0;
                cu_nop_o  = 1'b1;
            end
            fwd_a_o = fwd_sel(id_rn_i, id_use_i[0], ex_rd_i, ex_rf_we_i && !ex_load_i,
                              mem_rd_i, mem_rf_we_i, wb_rd_i, wb_rf_we_i);
            fwd_b_o = fwd_sel(id_rm_i, id_use_i[1], ex_rd_i, ex_rf_we_i && !ex_load_i,
                              mem_rd_i, mem_rf_we_i, wb_rd_i, wb_rf_we_i);
            fwd_c_o = fwd_sel(id_rd_i, id_use_i[2], ex_rd_i, ex_rf_we_i && !ex_load_i,
                              mem_rd_i, mem_rf_we_i, wb_rd_i, wb_rf_we_i);
        end
    end

    // A ready arriving on the last allowed wait cycle is a normal completion.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_err_d     = mem_err_q;
        stall_count_d = stall_count_q;

        if (state_q == ST_RUN) begin
            if (mem_req_i && !mem_ready_i) begin
                state_d    = ST_MEMWAIT;
                wait_cnt_d = 16'd0;
            end
        end else begin
            if (mem_ready_i) begin
                state_d    = ST_RUN;
                wait_cnt_d = 16'd0;
            end else if (wait_cnt_q == WAIT_LAST) begin
                state_d    = ST_RUN;
                wait_cnt_d = 16'd0;
                mem_err_d  = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 16'd1;
            end
        end

        if (!pc_ld_o && stall_count_q != {CNT_W{1'b1}})
            stall_count_d = stall_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!clr_i) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 16'd0;
            mem_err_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_err_q     <= mem_err_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign mem_err_o     = mem_err_q;
    assign stall_count_o = stall_count_q;

endmodule
